// File: rtl/clock_get_sampler.sv
// clock_get_sampler: Avalon-MM slave that synchronizes the asynchronous
// time-of-day bus, commits a value to the snapshot only after it has been
// stable for a programmable number of cycles, and flags each commit.
//
// Optional feature macro: CLOCK_GET_SAMPLER_IRQ_EN
//   defined   -> control bit1 (irq_en) exists, irq = irq_en & new
//   undefined -> control bit1 reads 0, irq tied low
module clock_get_sampler #(
    parameter int DATA_W     = 14,
    parameter int SETTLE_W   = 8,
    parameter int SETTLE_RST = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic [1:0]        address,
    input  logic              read,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [DATA_W-1:0] in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    localparam logic [1:0] A_SNAP   = 2'd0;
    localparam logic [1:0] A_CTRL   = 2'd1;
    localparam logic [1:0] A_STAT   = 2'd2;
    localparam logic [1:0] A_SETTLE = 2'd3;

    logic [DATA_W-1:0]   s1_q, s2_q;
    logic [1:0]          state_q, state_d;
    logic [DATA_W-1:0]   cand_q, cand_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]   snap_q, snap_d;
    logic [15:0]         chg_q, chg_d;
    logic                new_q, new_d;
    logic                ovr_q, ovr_d;
    logic                en_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [31:0]         rdata_q, rdata_d;
    logic                irq_en;
    logic                capture;

    logic wr_en, rd_en;
    logic [SETTLE_W-1:0] settle_eff, settle_last;
    logic busy;
    logic unused_wdata;

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & read;
    assign busy  = (state_q != ST_IDLE);

    // A programmed settle of 0 is treated as 1 so the window is never empty.
    assign settle_eff  = (settle_q == '0) ? SETTLE_W'(1) : settle_q;
    assign settle_last = settle_eff - SETTLE_W'(1);

    assign unused_wdata = ^writedata[31:SETTLE_W];

    // Two-flop synchronizer for the asynchronous time bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= in_port;
            s2_q <= s1_q;
        end
    end

    // Capture FSM next state: settle window restarts on any change; the
    // compare uses >= so lowering settle mid-window captures on the next
    // stable cycle instead of waiting for the counter to wrap.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        chg_d   = chg_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_q && (s2_q != snap_q)) begin
                    state_d = ST_SETTLE;
                    cand_d  = s2_q;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (s2_q != cand_q) begin
                    cand_d = s2_q;
                    cnt_d  = '0;
                end else if (cnt_q >= settle_last) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + SETTLE_W'(1);
                end
            end
            ST_CAPTURE: begin
                state_d = ST_IDLE;
                snap_d  = cand_q;
                chg_d   = chg_q + 16'd1;
                capture = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and snapshot registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            snap_q  <= '0;
            chg_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            chg_q   <= chg_d;
        end
    end

    // Flag next state: a capture wins over a snapshot read (new) and over a
    // write-1-to-clear (overrun), so no event is lost on a collision.
    always_comb begin
        new_d = new_q;
        ovr_d = ovr_q;
        if (capture) begin
            new_d = 1'b1;
        end else if (rd_en && (address == A_SNAP)) begin
            new_d = 1'b0;
        end
        if (capture && new_q) begin
            ovr_d = 1'b1;
        end else if (wr_en && (address == A_STAT) && writedata[1]) begin
            ovr_d = 1'b0;
        end
    end

    // New-data and overrun flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            new_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            new_q <= new_d;
            ovr_q <= ovr_d;
        end
    end

    // Control and settle registers, written at the strobe edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q     <= 1'b0;
            settle_q <= SETTLE_W'(SETTLE_RST);
        end else if (wr_en) begin
            if (address == A_CTRL)   en_q     <= writedata[0];
            if (address == A_SETTLE) settle_q <= writedata[SETTLE_W-1:0];
        end
    end

`ifdef CLOCK_GET_SAMPLER_IRQ_EN
    logic irq_en_q;

    // Interrupt enable bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
        end else if (wr_en && (address == A_CTRL)) begin
            irq_en_q <= writedata[1];
        end
    end

    assign irq_en = irq_en_q;
    assign irq    = irq_en_q & new_q;
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    // Read mux; bus idles at 0 when not being read.
    always_comb begin
        rdata_d = '0;
        if (rd_en) begin
            case (address)
                A_SNAP:   rdata_d = {{(32-DATA_W){1'b0}}, snap_q};
                A_CTRL:   rdata_d = {30'd0, irq_en, en_q};
                A_STAT:   rdata_d = {chg_q, 13'd0, busy, ovr_q, new_q};
                A_SETTLE: rdata_d = {{(32-SETTLE_W){1'b0}}, settle_q};
                default:  rdata_d = '0;
            endcase
        end
    end

    // Registered read data, one cycle of latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;

endmodule

// File: tb/tb_clock_get_sampler.sv
// Self-checking bench for clock_get_sampler: directed scenarios plus
// randomized segment sequences scored by a segment-level model.
module tb_clock_get_sampler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        chipselect;
    logic [1:0]  address;
    logic        read;
    logic        write_n;
    logic [31:0] writedata;
    logic [13:0] in_port;
    logic [31:0] readdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clock_get_sampler dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .address    (address),
        .read       (read),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick();
        d = readdata;
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic reset_dut();
        reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = '0; in_port = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = '0; in_port = 14'h1234;
        repeat (4) tick();
        checks++; if (readdata !== 32'd0) begin failures++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        reset_n = 1'b1;
        tick();
        bus_read(2'd0, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_snapshot got=%h exp=0", d); end
        bus_read(2'd1, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_control got=%h exp=0", d); end
        bus_read(2'd2, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_status got=%h exp=0", d); end
        bus_read(2'd3, d);
        checks++; if (d !== 32'd16) begin failures++; $display("FAIL reset_settle got=%h exp=10", d); end
    endtask

    // in_port changes just after edge E; capture edge is E+3+eff, flags
    // become visible after edge E+4+eff.
    task automatic test_latency(input int sv);
        logic [31:0] d;
        int eff;
        eff = (sv == 0) ? 1 : sv;
        reset_dut();
        bus_write(2'd3, sv);
        bus_write(2'd1, 32'd1);
        in_port = 14'h0A3B;
        repeat (3 + eff) tick();
        bus_read(2'd2, d);
        checks++; if (d[2:0] !== 3'b100) begin failures++; $display("FAIL latency_pre settle=%0d got=%h exp busy=1 new=0", sv, d); end
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0001_0001) begin failures++; $display("FAIL latency_post settle=%0d got=%h exp=00010001", sv, d); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'h0A3B) begin failures++; $display("FAIL latency_snapshot settle=%0d got=%h exp=0a3b", sv, d); end
        bus_read(2'd2, d);
        checks++; if (d[0] !== 1'b0) begin failures++; $display("FAIL latency_newclr settle=%0d got=%h exp new=0", sv, d); end
    endtask

    task automatic test_glitch_reject();
        logic [31:0] d;
        reset_dut();
        bus_write(2'd3, 32'd8);
        bus_write(2'd1, 32'd1);
        for (int i = 0; i < 10; i++) begin
            in_port = (i % 2 == 1) ? 14'h0101 : 14'h0100;
            repeat (4) tick();
        end
        repeat (30) tick();
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0001_0001) begin failures++; $display("FAIL glitch_status got=%h exp=00010001", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'h0101) begin failures++; $display("FAIL glitch_snapshot got=%h exp=0101", d); end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        reset_dut();
        bus_write(2'd3, 32'd2);
        bus_write(2'd1, 32'd1);
        in_port = 14'h0001;
        repeat (12) tick();
        in_port = 14'h0002;
        repeat (12) tick();
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0002_0003) begin failures++; $display("FAIL overrun_status got=%h exp=00020003", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'h0002) begin failures++; $display("FAIL overrun_snapshot got=%h exp=0002", d); end
        bus_write(2'd2, 32'h2);
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0002_0000) begin failures++; $display("FAIL overrun_clear got=%h exp=00020000", d); end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        reset_dut();
        bus_write(2'd3, 32'd20);
        bus_write(2'd1, 32'd1);
        in_port = 14'h0055;
        repeat (5) tick();
        bus_read(2'd2, d);
        checks++; if (d[2] !== 1'b1) begin failures++; $display("FAIL abort_busy got=%h exp busy=1", d); end
        bus_write(2'd1, 32'd0);
        tick();
        bus_read(2'd2, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL abort_idle got=%h exp=0", d); end
        repeat (30) tick();
        bus_read(2'd0, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL abort_snapshot got=%h exp=0", d); end
    endtask

    // Lowering settle below the running count captures on the next stable cycle.
    task automatic test_settle_rewrite();
        logic [31:0] d;
        reset_dut();
        bus_write(2'd3, 32'd20);
        bus_write(2'd1, 32'd1);
        in_port = 14'h0444;
        repeat (14) tick();
        bus_write(2'd3, 32'd3);
        repeat (2) tick();
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0001_0001) begin failures++; $display("FAIL rewrite_status got=%h exp=00010001", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'h0444) begin failures++; $display("FAIL rewrite_snapshot got=%h exp=0444", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        reset_dut();
        bus_write(2'd3, 32'd2);
        bus_write(2'd1, 32'd3);
        in_port = 14'h0777;
        repeat (10) tick();
        in_port = 14'h0778;
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (irq !== 1'b0 || readdata !== 32'd0) begin failures++; $display("FAIL midreset_async irq=%b rd=%h exp 0/0", irq, readdata); end
        tick();
        reset_n = 1'b1;
        tick();
        bus_read(2'd2, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL midreset_status got=%h exp=0", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL midreset_snapshot got=%h exp=0", d); end
        bus_read(2'd3, d);
        checks++; if (d !== 32'd16) begin failures++; $display("FAIL midreset_settle got=%h exp=10", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic        irq_pre;
        reset_dut();
        bus_write(2'd3, 32'd1);
        bus_write(2'd1, 32'd3);
        bus_read(2'd1, d);
`ifdef CLOCK_GET_SAMPLER_IRQ_EN
        checks++; if (d !== 32'd3) begin failures++; $display("FAIL irq_ctrl got=%h exp=3", d); end
`else
        checks++; if (d !== 32'd1) begin failures++; $display("FAIL irq_ctrl got=%h exp=1", d); end
`endif
        in_port = 14'h0222;
        repeat (4) tick();
        irq_pre = irq;
        tick();
        checks++; if (irq_pre !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq_pre); end
`ifdef CLOCK_GET_SAMPLER_IRQ_EN
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_assert got=%b exp=1", irq); end
        bus_read(2'd0, d);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq); end
        in_port = 14'h0333;
        repeat (4) tick();
        bus_read(2'd0, d);
        checks++; if (d !== 32'h0222) begin failures++; $display("FAIL irq_collide_data got=%h exp=0222", d); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_collide got=%b exp=1", irq); end
`else
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_tied got=%b exp=0", irq); end
        bus_read(2'd2, d);
        checks++; if (d[0] !== 1'b1) begin failures++; $display("FAIL irq_newflag got=%h exp new=1", d); end
`endif
    endtask

    // Segment-level reference: each held value is "short" (can never fill the
    // window) or "long" (fills it with margin). A long value commits when it
    // differs from the snapshot or when an earlier short value left the
    // sampler mid-window; a short value leaves it mid-window unless it simply
    // repeated the snapshot while idle.
    task automatic test_random();
        logic [31:0] d;
        int sv, len, caps, iter_caps;
        logic [13:0] v, prev, msnap;
        logic mbusy, long_seg;
        for (int it = 0; it < 4; it++) begin
            reset_dut();
            sv = $urandom_range(1, 4);
            bus_write(2'd3, sv);
            bus_write(2'd1, 32'd1);
            prev = '0; msnap = '0; mbusy = 1'b0; caps = 0;
            for (int seg = 0; seg < 25; seg++) begin
                do v = 14'($urandom_range(0, 16383)); while (v == prev);
                long_seg = (seg == 24) || ($urandom_range(0, 1) == 1);
                len = long_seg ? $urandom_range(sv + 4, sv + 8) : $urandom_range(1, sv);
                in_port = v;
                repeat (len) tick();
                if (long_seg) begin
                    if (mbusy || v != msnap) begin
                        caps++;
                        msnap = v;
                    end
                    mbusy = 1'b0;
                end else begin
                    mbusy = mbusy || (v != msnap);
                end
                prev = v;
            end
            repeat (6) tick();
            iter_caps = caps;
            bus_read(2'd2, d);
            checks++;
            if (d !== {16'(iter_caps), 13'd0, 1'b0, (iter_caps > 1), (iter_caps > 0)}) begin
                failures++; $display("FAIL random_status it=%0d settle=%0d got=%h caps_exp=%0d", it, sv, d, iter_caps);
            end
            bus_read(2'd0, d);
            checks++;
            if (d !== {18'd0, msnap}) begin
                failures++; $display("FAIL random_snapshot it=%0d got=%h exp=%h", it, d, msnap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency(1);
        test_latency(0);
        test_latency(5);
        test_glitch_reject();
        test_overrun();
        test_abort();
        test_settle_rewrite();
        test_reset_mid();
        test_irq();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
